// File: rtl/axis_mult_pkg.sv
// Shared types and defaults for the SPST pipelined stream multiplier.
package axis_mult_pkg;

    localparam int W_DEF      = 8;
    localparam int STAGES_DEF = 3;
    localparam int CNT_W_DEF  = 16;
    // Half operand width of the default configuration; the top derives its own from W.
    localparam int HALF       = W_DEF / 2;

    // Bit positions of the SPST flags inside the vector returned by rec_flags().
    localparam int FLAG_SPST_B = 0;
    localparam int FLAG_SPST_A = 1;
    localparam int FLAG_ZERO   = 2;
    localparam int N_FLAGS     = 3;

    // Control record travelling alongside each beat through stages 1 and 2.
    typedef struct packed {
        logic valid;
        logic last;
        logic sign;
        logic zero;
        logic spst_a;
        logic spst_b;
    } stage_rec_t;

    function automatic logic [N_FLAGS-1:0] rec_flags(input stage_rec_t r);
        logic [N_FLAGS-1:0] f;
        f              = '0;
        f[FLAG_SPST_B] = r.spst_b;
        f[FLAG_SPST_A] = r.spst_a;
        f[FLAG_ZERO]   = r.zero;
        return f;
    endfunction

endpackage

// File: rtl/spst_detect.sv
// Classifies an operand magnitude for spurious power suppression:
// whole magnitude zero, and upper half zero.
module spst_detect #(
    parameter int W = 8
) (
    input  logic [W-1:0] mag,
    output logic         is_zero,
    output logic         hi_zero
);

    // Pure combinational classification of the magnitude.
    always_comb begin
        is_zero = (mag == '0);
        hi_zero = (mag[W-1:W/2] == '0);
    end

endmodule

// File: rtl/axis_mult_spst_pipe.sv
// AXI-Stream pipelined W x W multiplier with per-beat signed/unsigned mode,
// global-enable backpressure and SPST gating of partial-product registers.
// Stage 1 registers magnitudes and flags, stage 2 the four half-width partial
// products, stage 3 the signed sum; further stages only retime the output.
module axis_mult_spst_pipe
    import axis_mult_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*W-1:0]   s_axis_tdata,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [2*W-1:0]   m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] spst_cnt
);

    localparam int H = W / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic           stall;
    logic           out_valid;
    logic           out_last;
    logic [2*W-1:0] out_data;

    assign stall         = out_valid & ~m_axis_tready;
    assign s_axis_tready = ~stall;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign m_axis_tdata  = out_data;

    // ---------------------------------------------------------------- stage 1
    logic [W-1:0] a_in, b_in, a_mag, b_mag;
    logic         a_zero, a_hi_zero, b_zero, b_hi_zero;

    // Split the beat and convert signed operands to magnitudes (-2^(W-1) -> 2^(W-1)).
    always_comb begin
        a_in  = s_axis_tdata[W-1:0];
        b_in  = s_axis_tdata[2*W-1:W];
        a_mag = (s_axis_tuser & a_in[W-1]) ? (~a_in + 1'b1) : a_in;
        b_mag = (s_axis_tuser & b_in[W-1]) ? (~b_in + 1'b1) : b_in;
    end

    spst_detect #(.W(W)) u_det_a (
        .mag     (a_mag),
        .is_zero (a_zero),
        .hi_zero (a_hi_zero)
    );

    spst_detect #(.W(W)) u_det_b (
        .mag     (b_mag),
        .is_zero (b_zero),
        .hi_zero (b_hi_zero)
    );

    logic [W-1:0]     a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    stage_rec_t       rec1_q, rec1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Stage-1 capture and the saturating count of beats leaving stage 1 with a flag set.
    always_comb begin
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        rec1_d  = rec1_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            rec1_d.valid  = s_axis_tvalid;
            rec1_d.last   = s_axis_tlast;
            rec1_d.sign   = s_axis_tuser & (a_in[W-1] ^ b_in[W-1]);
            rec1_d.zero   = a_zero | b_zero;
            rec1_d.spst_a = a_hi_zero;
            rec1_d.spst_b = b_hi_zero;
            if (s_axis_tvalid) begin
                a_mag_d = a_mag;
                b_mag_d = b_mag;
            end
            if (rec1_q.valid && (|rec_flags(rec1_q)) && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag_q <= '0;
            b_mag_q <= '0;
            rec1_q  <= '0;
            cnt_q   <= '0;
        end else begin
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            rec1_q  <= rec1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spst_cnt = cnt_q;

    // ------------------------------------------------- partial products (comb)
    logic [W-1:0] ll_c, lh_c, hl_c, hh_c;

    // Half-width products of the stage-1 magnitudes; operands zero-extended to W.
    always_comb begin
        ll_c = {{H{1'b0}}, a_mag_q[H-1:0]} * {{H{1'b0}}, b_mag_q[H-1:0]};
        lh_c = {{H{1'b0}}, a_mag_q[H-1:0]} * {{H{1'b0}}, b_mag_q[W-1:H]};
        hl_c = {{H{1'b0}}, a_mag_q[W-1:H]} * {{H{1'b0}}, b_mag_q[H-1:0]};
        hh_c = {{H{1'b0}}, a_mag_q[W-1:H]} * {{H{1'b0}}, b_mag_q[W-1:H]};
    end

    // What the summing stage consumes: registered products, or direct ones when STAGES==2.
    logic [W-1:0] ll_s, lh_s, hl_s, hh_s;
    stage_rec_t   rec_s;

    generate
        if (STAGES >= 3) begin : g_pp_reg
            logic [W-1:0] ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
            stage_rec_t   rec2_q, rec2_d;

            // Stage-2 loads; groups made redundant by a zero upper half are left untouched.
            always_comb begin
                ll_d   = ll_q;
                lh_d   = lh_q;
                hl_d   = hl_q;
                hh_d   = hh_q;
                rec2_d = rec2_q;
                if (!stall) begin
                    rec2_d = rec1_q;
                    if (rec1_q.valid && !rec1_q.zero) begin
                        ll_d = ll_c;
                        if (!rec1_q.spst_b) lh_d = lh_c;
                        if (!rec1_q.spst_a) hl_d = hl_c;
                        if (!rec1_q.spst_a && !rec1_q.spst_b) hh_d = hh_c;
                    end
                end
            end

            // Stage-2 registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ll_q   <= '0;
                    lh_q   <= '0;
                    hl_q   <= '0;
                    hh_q   <= '0;
                    rec2_q <= '0;
                end else begin
                    ll_q   <= ll_d;
                    lh_q   <= lh_d;
                    hl_q   <= hl_d;
                    hh_q   <= hh_d;
                    rec2_q <= rec2_d;
                end
            end

            assign ll_s  = ll_q;
            assign lh_s  = lh_q;
            assign hl_s  = hl_q;
            assign hh_s  = hh_q;
            assign rec_s = rec2_q;
        end else begin : g_pp_comb
            assign ll_s  = ll_c;
            assign lh_s  = lh_c;
            assign hl_s  = hl_c;
            assign hh_s  = hh_c;
            assign rec_s = rec1_q;
        end
    endgenerate

    // ------------------------------------------------------------ sum stage
    // Held groups are masked by the carried flags, never trusted by register content.
    function automatic logic [2*W-1:0] spst_sum(
        input logic [W-1:0] ll,
        input logic [W-1:0] lh,
        input logic [W-1:0] hl,
        input logic [W-1:0] hh,
        input stage_rec_t   r
    );
        logic [2*W-1:0] ll_m, mid_m, hh_m, s;
        ll_m  = r.zero ? '0 : {{W{1'b0}}, ll};
        mid_m = '0;
        if (!r.zero && !r.spst_b) mid_m = mid_m + {{W{1'b0}}, lh};
        if (!r.zero && !r.spst_a) mid_m = mid_m + {{W{1'b0}}, hl};
        hh_m  = (r.zero | r.spst_a | r.spst_b) ? '0 : {hh, {W{1'b0}}};
        s     = ll_m + (mid_m << H) + hh_m;
        if (r.zero) begin
            s = '0;
        end else if (r.sign) begin
            s = ~s + 1'b1;
        end
        return s;
    endfunction

    logic [2*W-1:0] res_q, res_d;
    logic           res_valid_q, res_valid_d, res_last_q, res_last_d;

    // Sum/negate stage; data only reloads for a valid beat.
    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        if (!stall) begin
            res_valid_d = rec_s.valid;
            res_last_d  = rec_s.last;
            if (rec_s.valid) begin
                res_d = spst_sum(ll_s, lh_s, hl_s, hh_s, rec_s);
            end
        end
    end

    // Sum-stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
        end else begin
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
        end
    end

    // ------------------------------------------------------ output retiming
    generate
        if (STAGES > 3) begin : g_retime
            localparam int NRT = STAGES - 3;
            logic [2*W-1:0] rt_data_q [NRT];
            logic [2*W-1:0] rt_data_d [NRT];
            logic [2*W-1:0] rt_src    [NRT];
            logic [NRT-1:0] rt_valid_q, rt_valid_d, rt_last_q, rt_last_d;
            logic [NRT-1:0] rt_src_v, rt_src_l;

            // Shift the retiming chain by one slot whenever the pipeline is not stalled.
            always_comb begin
                rt_data_d   = rt_data_q;
                rt_valid_d  = rt_valid_q;
                rt_last_d   = rt_last_q;
                rt_src[0]   = res_q;
                rt_src_v    = '0;
                rt_src_l    = '0;
                rt_src_v[0] = res_valid_q;
                rt_src_l[0] = res_last_q;
                for (int i = 1; i < NRT; i++) begin
                    rt_src[i]   = rt_data_q[i-1];
                    rt_src_v[i] = rt_valid_q[i-1];
                    rt_src_l[i] = rt_last_q[i-1];
                end
                if (!stall) begin
                    rt_valid_d = rt_src_v;
                    rt_last_d  = rt_src_l;
                    for (int i = 0; i < NRT; i++) begin
                        if (rt_src_v[i]) rt_data_d[i] = rt_src[i];
                    end
                end
            end

            // Retiming registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < NRT; i++) rt_data_q[i] <= '0;
                    rt_valid_q <= '0;
                    rt_last_q  <= '0;
                end else begin
                    rt_data_q  <= rt_data_d;
                    rt_valid_q <= rt_valid_d;
                    rt_last_q  <= rt_last_d;
                end
            end

            assign out_data  = rt_data_q[NRT-1];
            assign out_valid = rt_valid_q[NRT-1];
            assign out_last  = rt_last_q[NRT-1];
        end else begin : g_no_retime
            assign out_data  = res_q;
            assign out_valid = res_valid_q;
            assign out_last  = res_last_q;
        end
    endgenerate

endmodule

// File: tb/tb_axis_mult_spst_pipe.sv
// Bench for the SPST stream multiplier: an 8-bit/3-stage instance driven through a
// scoreboard, plus a 16-bit/5-stage/2-bit-counter instance for parameter corners.
module tb_axis_mult_spst_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit, 3-stage instance
    logic [15:0] s_tdata;
    logic        s_tuser, s_tlast, s_tvalid, s_tready;
    logic [15:0] m_tdata;
    logic        m_tlast, m_tvalid, m_tready;
    logic [15:0] cnt8;

    axis_mult_spst_pipe #(.W(8), .STAGES(3), .CNT_W(16)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .spst_cnt      (cnt8)
    );

    // 16-bit, 5-stage, 2-bit counter instance
    logic [31:0] w_tdata;
    logic        w_tuser, w_tlast, w_tvalid, w_sready;
    logic [31:0] w_mdata;
    logic        w_mlast, w_mvalid, w_mready;
    logic [1:0]  cnt16;

    axis_mult_spst_pipe #(.W(16), .STAGES(5), .CNT_W(2)) dut16 (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (w_tdata),
        .s_axis_tuser  (w_tuser),
        .s_axis_tlast  (w_tlast),
        .s_axis_tvalid (w_tvalid),
        .s_axis_tready (w_sready),
        .m_axis_tdata  (w_mdata),
        .m_axis_tlast  (w_mlast),
        .m_axis_tvalid (w_mvalid),
        .m_axis_tready (w_mready),
        .spst_cnt      (cnt16)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [15:0] cur_exp;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    logic        last_in_hs;

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic u);
        longint sa, sb, p;
        sa = u ? longint'($signed(a)) : longint'(a);
        sb = u ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[15:0];
    endfunction

    // One clock: observe handshakes just before the edge, then advance to edge+1.
    task automatic step();
        logic exp_rdy;
        #2;
        if (!rst) begin
            if (prev_stall) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last)
                    $display("FAIL hold_stable: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                else n_pass++;
            end
            exp_rdy = !(m_tvalid && !m_tready);
            n_checks++;
            if (s_tready !== exp_rdy)
                $display("FAIL s_tready: got %b, need %b", s_tready, exp_rdy);
            else n_pass++;
            if (s_tvalid && s_tready) sb_q.push_back({cur_exp, s_tlast});
            if (m_tvalid && m_tready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got d=%h with empty scoreboard, need no beat", m_tdata);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (m_tdata !== sb_e.d || m_tlast !== sb_e.l)
                        $display("FAIL sb_beat: got d=%h l=%b, need d=%h l=%b",
                                 m_tdata, m_tlast, sb_e.d, sb_e.l);
                    else n_pass++;
                end
            end
        end
        last_in_hs = s_tvalid && s_tready && !rst;
        prev_stall = m_tvalid && !m_tready && !rst;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        w_tvalid = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic u,
                              input logic l, input logic [15:0] e);
        s_tdata  = {b, a};
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        cur_exp  = e;
        step();
    endtask

    task automatic drain();
        int n;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        n = 0;
        while (sb_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL drain_timeout: got %0d beats outstanding, need 0", sb_q.size());
        else n_pass++;
        step();
        n_checks++;
        if (m_tvalid !== 1'b0) $display("FAIL drain_idle: got tvalid=%b, need 0", m_tvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        w_tvalid = 1'b0;
        m_tready = 1'b1;
        w_mready = 1'b1;
        step();
        step();
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 16'h0 || m_tlast !== 1'b0 || cnt8 !== 16'h0)
            $display("FAIL reset_outputs: got v=%b d=%h l=%b cnt=%0d, need 0/0/0/0",
                     m_tvalid, m_tdata, m_tlast, cnt8);
        else n_pass++;
        n_checks++;
        if (w_mvalid !== 1'b0 || w_mdata !== 32'h0 || cnt16 !== 2'd0)
            $display("FAIL reset_wide: got v=%b d=%h cnt=%0d, need 0/0/0", w_mvalid, w_mdata, cnt16);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_tready !== 1'b1) $display("FAIL reset_tready: got %b, need 1", s_tready);
        else n_pass++;
        sb_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic test_unsigned_stream();
        logic [7:0]  av[4];
        logic [7:0]  bv[4];
        logic [15:0] ev[4];
        av = '{8'd15, 8'd255, 8'd255, 8'd100};
        bv = '{8'd10, 8'd1,   8'd255, 8'd100};
        ev = '{16'd150, 16'd255, 16'd65025, 16'd10000};
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(av[i], bv[i], 1'b0, (i == 3), ev[i]);
            if (i == 1) begin
                n_checks++;
                if (m_tvalid !== 1'b0) $display("FAIL latency_early: got tvalid=%b after 2 edges, need 0", m_tvalid);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 16'd150)
                    $display("FAIL latency3: got v=%b d=%0d after 3 edges, need v=1 d=150", m_tvalid, m_tdata);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 16'd255)
                    $display("FAIL full_rate: got v=%b d=%0d next cycle, need v=1 d=255", m_tvalid, m_tdata);
                else n_pass++;
            end
        end
        drain();
    endtask

    task automatic test_signed_mixed();
        m_tready = 1'b1;
        drive_beat(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000);
        drive_beat(8'hFF, 8'h01, 1'b1, 1'b1, 16'hFFFF);
        drive_beat(8'h7F, 8'h80, 1'b1, 1'b0, 16'hC080);
        drive_beat(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01);
        drive_beat(8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001);
        drive_beat(8'h80, 8'h02, 1'b0, 1'b1, 16'h0100);
        drive_beat(8'h80, 8'h02, 1'b1, 1'b0, 16'hFF00);
        drive_beat(8'h00, 8'h85, 1'b1, 1'b1, 16'h0000);
        drain();
    endtask

    task automatic test_spst_counter();
        reset_dut();
        m_tready = 1'b1;
        drive_beat(8'd12, 8'd12, 1'b0, 1'b0, 16'd144);
        drive_beat(8'd0, 8'd200, 1'b0, 1'b1, 16'd0);
        drain();
        n_checks++;
        if (cnt8 !== 16'd2) $display("FAIL spst_cnt_two: got %0d, need 2", cnt8);
        else n_pass++;
        drive_beat(8'd255, 8'd255, 1'b0, 1'b0, 16'd65025);
        drain();
        n_checks++;
        if (cnt8 !== 16'd2) $display("FAIL spst_cnt_full_op: got %0d, need 2", cnt8);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int         sent, cyc;
        logic [7:0] a, b;
        logic       u;
        sent       = 0;
        cyc        = 0;
        s_tvalid   = 1'b0;
        last_in_hs = 1'b0;
        while (sent < 200 && cyc < 5000) begin
            if (!s_tvalid || last_in_hs) begin
                if (($urandom_range(0, 99) < 70)) begin
                    a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                    b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                    u = 1'($urandom_range(0, 1));
                    s_tdata  = {b, a};
                    s_tuser  = u;
                    s_tlast  = 1'($urandom_range(0, 1));
                    s_tvalid = 1'b1;
                    cur_exp  = model8(a, b, u);
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready = 1'($urandom_range(0, 1));
            step();
            if (last_in_hs) sent++;
            cyc++;
        end
        n_checks++;
        if (sent != 200) $display("FAIL bp_sent: got %0d beats accepted, need 200", sent);
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_midstream();
        reset_dut();
        m_tready = 1'b0;
        drive_beat(8'd12, 8'd12, 1'b0, 1'b0, 16'd144);
        drive_beat(8'd12, 8'd12, 1'b0, 1'b0, 16'd144);
        drive_beat(8'd12, 8'd12, 1'b0, 1'b1, 16'd144);
        n_checks++;
        if (cnt8 !== 16'd2 || m_tvalid !== 1'b1)
            $display("FAIL mid_fill: got cnt=%0d v=%b, need cnt=2 v=1", cnt8, m_tvalid);
        else n_pass++;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        step();
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 16'h0 || cnt8 !== 16'd0)
            $display("FAIL mid_reset: got v=%b d=%h cnt=%0d, need 0/0/0", m_tvalid, m_tdata, cnt8);
        else n_pass++;
        rst = 1'b0;
        sb_q.delete();
        prev_stall = 1'b0;
        m_tready   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (m_tvalid !== 1'b0) $display("FAIL stale_beat: got tvalid=%b cycle %0d, need 0", m_tvalid, i);
            else n_pass++;
        end
    endtask

    task automatic wide_one(input logic [15:0] a, input logic [15:0] b, input logic u,
                            input logic [31:0] e, input string tag);
        int k;
        w_tdata  = {b, a};
        w_tuser  = u;
        w_tlast  = 1'b1;
        w_tvalid = 1'b1;
        step();
        w_tvalid = 1'b0;
        k = 1;
        while (!w_mvalid && k < 12) begin
            step();
            k++;
        end
        n_checks++;
        if (k != 5 || w_mdata !== e || w_mlast !== 1'b1)
            $display("FAIL wide_%s: got lat=%0d d=%h l=%b, need lat=5 d=%h l=1", tag, k, w_mdata, w_mlast, e);
        else n_pass++;
        step();
    endtask

    task automatic test_wide_params();
        reset_dut();
        w_mready = 1'b1;
        wide_one(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "max_unsigned");
        wide_one(16'h8000, 16'h8000, 1'b1, 32'h40000000, "min_signed");
        n_checks++;
        if (cnt16 !== 2'd0) $display("FAIL wide_cnt_idle: got %0d, need 0", cnt16);
        else n_pass++;
        w_tdata  = {16'd1, 16'd1};
        w_tuser  = 1'b0;
        w_tlast  = 1'b0;
        w_tvalid = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (cnt16 !== 2'd2) $display("FAIL wide_cnt_incr: got %0d, need 2", cnt16);
        else n_pass++;
        step();
        step();
        w_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (cnt16 !== 2'd3) $display("FAIL wide_cnt_sat: got %0d, need 3", cnt16);
        else n_pass++;
    endtask

    initial begin
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        w_tdata  = '0;
        w_tuser  = 1'b0;
        w_tlast  = 1'b0;
        w_tvalid = 1'b0;
        w_mready = 1'b1;
        cur_exp  = '0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_unsigned_stream();
        test_signed_mixed();
        test_spst_counter();
        test_backpressure();
        test_reset_midstream();
        test_wide_params();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by t=%0t, need completion", $time);
        $fatal(1);
    end

endmodule
